vme_read_responder: RTL and testbench

Responder end of the VME read-command interface driven by the tensor-load command generator. Accepts `{addr, len, tag}` read commands, queues them, walks each burst beat-by-beat against a 1-cycle-latency synchronous memory read port, and returns tagged data beats with `last` under valid/ready backpressure. It serves as the DRAM-side model/bridge behind the VME read channel in simulation and in the FPGA test platform.

---
 rtl/vme_pkg.sv | 20 ++
 rtl/vme_cmd_queue.sv | 66 ++++++
 rtl/vme_read_responder.sv | 165 ++++++++++++++++
 tb/tb_vme_read_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// Shared widths and packed payload types for the VME read channel.
package vme_pkg;
   localparam int VME_DATA_BITS = 64;
   localparam int VME_ADDR_BITS = 32;
   localparam int VME_LEN_BITS  = 8;
   localparam int VME_TAG_BITS  = 21;
   localparam int VME_CMD_DEPTH = 4;

   typedef struct packed {
      logic [VME_ADDR_BITS-1:0] addr;
      logic [VME_LEN_BITS-1:0]  len;
      logic [VME_TAG_BITS-1:0]  tag;
   } vme_cmd_t;

   typedef struct packed {
      logic [VME_DATA_BITS-1:0] data;
      logic [VME_TAG_BITS-1:0]  tag;
      logic                     last;
   } vme_rd_beat_t;
endpackage

// File: rtl/vme_cmd_queue.sv
// Generic sync FIFO; head visible the cycle after push.
// Push is dropped when full (callers gate on !full); pop is ignored when empty.
module vme_cmd_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_push  = push_vld & ~full;
   assign do_pop   = pop & ~empty;
   assign head_dat = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/vme_read_responder.sv
// VME read responder: queues {addr,len,tag} commands, issues one memory read per beat, returns tagged beats.
// Cmd fire to first data valid is 4 cycles; 1 beat/cycle with ready high; reads stall so the 2-entry buffer never overflows.
module vme_read_responder
   import vme_pkg::*;
#(
   parameter int DATA_BITS = VME_DATA_BITS,
   parameter int ADDR_BITS = VME_ADDR_BITS,
   parameter int LEN_BITS  = VME_LEN_BITS,
   parameter int TAG_BITS  = VME_TAG_BITS,
   parameter int CMD_DEPTH = VME_CMD_DEPTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_vmeCmd_valid,
   output logic                 io_vmeCmd_ready,
   input  logic [ADDR_BITS-1:0] io_vmeCmd_bits_addr,
   input  logic [LEN_BITS-1:0]  io_vmeCmd_bits_len,
   input  logic [TAG_BITS-1:0]  io_vmeCmd_bits_tag,
   output logic                 io_vmeData_valid,
   input  logic                 io_vmeData_ready,
   output logic [DATA_BITS-1:0] io_vmeData_bits_data,
   output logic [TAG_BITS-1:0]  io_vmeData_bits_tag,
   output logic                 io_vmeData_bits_last,
   output logic                 io_mem_en,
   output logic [ADDR_BITS-1:0] io_mem_addr,
   input  logic [DATA_BITS-1:0] io_mem_rdata,
   output logic                 io_busy
);
   localparam logic [0:0]           ST_IDLE    = 1'b0;
   localparam logic [0:0]           ST_BURST   = 1'b1;
   localparam logic [ADDR_BITS-1:0] BEAT_BYTES = ADDR_BITS'(DATA_BITS / 8);
   localparam logic [LEN_BITS:0]    ONE_BEAT   = (LEN_BITS + 1)'(1);

   vme_cmd_t     cmd_in, cmd_head;
   vme_rd_beat_t beat_in, beat_head;
   logic         cmd_full, cmd_empty, cmd_pop;
   logic         buf_full, buf_empty, buf_pop;
   logic [1:0]   buf_occ;
   logic         issue_ok, issue;

   logic [0:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_BITS:0]    beats_left_q, beats_left_d;
   logic [TAG_BITS-1:0]  cur_tag_q, cur_tag_d;
   logic                 inflight_q, inflight_d;
   logic [TAG_BITS-1:0]  sb_tag_q, sb_tag_d;
   logic                 sb_last_q, sb_last_d;

   always_comb begin
      cmd_in      = '0;
      cmd_in.addr = io_vmeCmd_bits_addr;
      cmd_in.len  = io_vmeCmd_bits_len;
      cmd_in.tag  = io_vmeCmd_bits_tag;
   end

   vme_cmd_queue #(.WIDTH($bits(vme_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_q (
      .clk      (clock),
      .rst_n    (reset),
      .push_vld (io_vmeCmd_valid),
      .push_dat (cmd_in),
      .pop      (cmd_pop),
      .head_dat (cmd_head),
      .full     (cmd_full),
      .empty    (cmd_empty)
   );

   assign io_vmeCmd_ready = ~cmd_full;

   // Reserve a buffer slot for every read in flight so a returning beat always has room.
   assign buf_pop  = io_vmeData_valid & io_vmeData_ready;
   assign buf_occ  = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
   assign issue_ok = ({1'b0, buf_occ} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, buf_pop});

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      cur_tag_d    = cur_tag_q;
      inflight_d   = 1'b0;
      sb_tag_d     = sb_tag_q;
      sb_last_d    = sb_last_q;
      cmd_pop      = 1'b0;
      issue        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!cmd_empty) begin
               cmd_pop      = 1'b1;
               cur_addr_d   = cmd_head.addr;
               beats_left_d = (LEN_BITS + 1)'(cmd_head.len) + 1'b1;
               cur_tag_d    = cmd_head.tag;
               state_d      = ST_BURST;
            end
         end
         ST_BURST: begin
            if (issue_ok) begin
               issue        = 1'b1;
               inflight_d   = 1'b1;
               sb_tag_d     = cur_tag_q;
               sb_last_d    = (beats_left_q == ONE_BEAT);
               cur_addr_d   = cur_addr_q + BEAT_BYTES;
               beats_left_d = beats_left_q - 1'b1;
               if (beats_left_q == ONE_BEAT) begin
                  if (!cmd_empty) begin
                     cmd_pop      = 1'b1;
                     cur_addr_d   = cmd_head.addr;
                     beats_left_d = (LEN_BITS + 1)'(cmd_head.len) + 1'b1;
                     cur_tag_d    = cmd_head.tag;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cur_addr_q   <= '0;
         beats_left_q <= '0;
         cur_tag_q    <= '0;
         inflight_q   <= 1'b0;
         sb_tag_q     <= '0;
         sb_last_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         beats_left_q <= beats_left_d;
         cur_tag_q    <= cur_tag_d;
         inflight_q   <= inflight_d;
         sb_tag_q     <= sb_tag_d;
         sb_last_q    <= sb_last_d;
      end
   end

   assign io_mem_en   = issue;
   assign io_mem_addr = issue ? cur_addr_q : '0;

   always_comb begin
      beat_in      = '0;
      beat_in.data = io_mem_rdata;
      beat_in.tag  = sb_tag_q;
      beat_in.last = sb_last_q;
   end

   vme_cmd_queue #(.WIDTH($bits(vme_rd_beat_t)), .DEPTH(2)) u_out_buf (
      .clk      (clock),
      .rst_n    (reset),
      .push_vld (inflight_q),
      .push_dat (beat_in),
      .pop      (buf_pop),
      .head_dat (beat_head),
      .full     (buf_full),
      .empty    (buf_empty)
   );

   assign io_vmeData_valid     = ~buf_empty;
   assign io_vmeData_bits_data = beat_head.data;
   assign io_vmeData_bits_tag  = beat_head.tag;
   assign io_vmeData_bits_last = beat_head.last;

   assign io_busy = ~cmd_empty | (state_q == ST_BURST) | inflight_q | ~buf_empty;
endmodule

// File: tb/tb_vme_read_responder.sv
// Directed bench: a queue-based beat model checked every cycle, plus literal latency/data pins.
`timescale 1ns/1ps
module tb_vme_read_responder;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_vmeCmd_valid = 1'b0;
   logic        io_vmeCmd_ready;
   logic [31:0] io_vmeCmd_bits_addr = '0;
   logic [7:0]  io_vmeCmd_bits_len = '0;
   logic [20:0] io_vmeCmd_bits_tag = '0;
   logic        io_vmeData_valid;
   logic        io_vmeData_ready = 1'b1;
   logic [63:0] io_vmeData_bits_data;
   logic [20:0] io_vmeData_bits_tag;
   logic        io_vmeData_bits_last;
   logic        io_mem_en;
   logic [31:0] io_mem_addr;
   logic [63:0] io_mem_rdata = '0;
   logic        io_busy;

   always #5 clock = ~clock;

   vme_read_responder dut (
      .clock(clock), .reset(reset),
      .io_vmeCmd_valid(io_vmeCmd_valid), .io_vmeCmd_ready(io_vmeCmd_ready),
      .io_vmeCmd_bits_addr(io_vmeCmd_bits_addr), .io_vmeCmd_bits_len(io_vmeCmd_bits_len),
      .io_vmeCmd_bits_tag(io_vmeCmd_bits_tag),
      .io_vmeData_valid(io_vmeData_valid), .io_vmeData_ready(io_vmeData_ready),
      .io_vmeData_bits_data(io_vmeData_bits_data), .io_vmeData_bits_tag(io_vmeData_bits_tag),
      .io_vmeData_bits_last(io_vmeData_bits_last),
      .io_mem_en(io_mem_en), .io_mem_addr(io_mem_addr), .io_mem_rdata(io_mem_rdata),
      .io_busy(io_busy)
   );

   typedef struct {
      logic [63:0] data;
      logic [20:0] tag;
      logic        last;
   } beat_s;

   int unsigned checks = 0;
   int unsigned passes = 0;
   int          cyc = 0;
   int          fire_cyc = 0;
   int          idle_cyc = 0;
   int          outstanding = 0;
   int          ready_mode = 1;   // 0 low, 1 high, 2 random
   beat_s       exp_q[$];
   logic [31:0] exp_addr_q[$];
   int          mem_cyc_log[$];
   logic [31:0] mem_addr_log[$];
   int          beat_cyc_log[$];
   beat_s       beat_log[$];

   function automatic logic [63:0] memfn(input logic [31:0] a);
      return {~a, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_logs();
      mem_cyc_log.delete();
      mem_addr_log.delete();
      beat_cyc_log.delete();
      beat_log.delete();
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous memory: rdata for the address presented in one cycle appears in the next.
   initial begin : memory_model
      logic [31:0] pa;
      forever begin
         @(negedge clock);
         pa = io_mem_addr;
         @(posedge clock);
         #1 io_mem_rdata = memfn(pa);
      end
   end

   initial begin : ready_driver
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       io_vmeData_ready = 1'b0;
            1:       io_vmeData_ready = 1'b1;
            default: io_vmeData_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      logic [31:0] a;
      beat_s       e, b, hold_b;
      logic        hold_vld;
      hold_vld = 1'b0;
      hold_b   = '{64'h0, 21'h0, 1'b0};
      forever begin
         @(negedge clock);
         if (!reset) begin
            exp_q.delete();
            exp_addr_q.delete();
            outstanding = 0;
            hold_vld    = 1'b0;
         end else begin
            if (io_vmeCmd_valid && io_vmeCmd_ready) begin
               fire_cyc = cyc;
               for (int i = 0; i <= int'(io_vmeCmd_bits_len); i++) begin
                  a = io_vmeCmd_bits_addr + 32'(i * 8);
                  exp_addr_q.push_back(a);
                  exp_q.push_back('{memfn(a), io_vmeCmd_bits_tag, (i == int'(io_vmeCmd_bits_len))});
               end
            end
            if (io_mem_en) begin
               mem_cyc_log.push_back(cyc);
               mem_addr_log.push_back(io_mem_addr);
               outstanding++;
               if (exp_addr_q.size() == 0) check("mem_en_without_cmd", 64'(io_mem_en), 64'd0);
               else check("mem_addr", 64'(io_mem_addr), 64'(exp_addr_q.pop_front()));
            end
            b = '{io_vmeData_bits_data, io_vmeData_bits_tag, io_vmeData_bits_last};
            if (hold_vld) begin
               check("hold_valid", 64'(io_vmeData_valid), 64'd1);
               check("hold_data", b.data, hold_b.data);
               check("hold_tag_last", {b.tag, b.last}, {hold_b.tag, hold_b.last});
            end
            if (io_vmeData_valid && io_vmeData_ready) begin
               beat_cyc_log.push_back(cyc);
               beat_log.push_back(b);
               outstanding--;
               if (exp_q.size() == 0) begin
                  check("beat_without_cmd", 64'(io_vmeData_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", b.data, e.data);
                  check("beat_tag", 64'(b.tag), 64'(e.tag));
                  check("beat_last", 64'(b.last), 64'(e.last));
               end
            end
            check("occupancy_le2", 64'(outstanding <= 2), 64'd1);
            hold_vld = io_vmeData_valid && !io_vmeData_ready;
            hold_b   = b;
         end
      end
   end

   task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [20:0] t,
                           input int maxw, output bit ok);
      io_vmeCmd_valid     = 1'b1;
      io_vmeCmd_bits_addr = a;
      io_vmeCmd_bits_len  = l;
      io_vmeCmd_bits_tag  = t;
      ok = 1'b0;
      for (int i = 0; i < maxw && !ok; i++) begin
         @(negedge clock);
         if (io_vmeCmd_ready) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      io_vmeCmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxc && !done; i++) begin
         @(negedge clock);
         if (!io_busy && exp_q.size() == 0) begin
            done     = 1'b1;
            idle_cyc = cyc;
         end
      end
      check(name, 64'(done), 64'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ok;
      int accepted;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("rst_cmd_ready", 64'(io_vmeCmd_ready), 64'd1);
      check("rst_data_valid", 64'(io_vmeData_valid), 64'd0);
      check("rst_busy", 64'(io_busy), 64'd0);
      check("rst_mem_en", {io_mem_en, io_mem_addr}, 64'd0);
      @(posedge clock);
      #1;

      // single beat: latency and literal data
      clear_logs();
      send_cmd(32'h100, 8'd0, 21'h5, 10, ok);
      check("t1_accept", 64'(ok), 64'd1);
      wait_idle("t1_drain", 40);
      check("t1_beats", 64'(beat_log.size()), 64'd1);
      check("t1_idle_lat", 64'(idle_cyc - fire_cyc), 64'd5);
      if (mem_cyc_log.size() > 0) check("t1_mem_lat", 64'(mem_cyc_log[0] - fire_cyc), 64'd2);
      if (beat_log.size() > 0) begin
         check("t1_data_lat", 64'(beat_cyc_log[0] - fire_cyc), 64'd4);
         check("t1_data", beat_log[0].data, 64'hFFFFFEFF_00000100);
         check("t1_tag_last", {beat_log[0].tag, beat_log[0].last}, {21'h5, 1'b1});
      end

      // 4-beat burst: consecutive addresses and beats
      clear_logs();
      send_cmd(32'h1000, 8'd3, 21'h2A, 10, ok);
      wait_idle("t2_drain", 40);
      check("t2_reads", 64'(mem_addr_log.size()), 64'd4);
      check("t2_beats", 64'(beat_log.size()), 64'd4);
      if (mem_addr_log.size() == 4) begin
         check("t2_addr0", 64'(mem_addr_log[0]), 64'h1000);
         check("t2_addr3", 64'(mem_addr_log[3]), 64'h1018);
         check("t2_read_span", 64'(mem_cyc_log[3] - mem_cyc_log[0]), 64'd3);
      end
      if (beat_log.size() == 4) begin
         check("t2_lasts", {beat_log[0].last, beat_log[1].last, beat_log[2].last, beat_log[3].last}, 64'b0001);
         check("t2_beat_span", 64'(beat_cyc_log[3] - beat_cyc_log[0]), 64'd3);
      end

      // 8 beats under random ready
      clear_logs();
      ready_mode = 2;
      send_cmd(32'h4000, 8'd7, 21'h1FFFFF, 10, ok);
      wait_idle("t3_drain", 300);
      ready_mode = 1;
      check("t3_beats", 64'(beat_log.size()), 64'd8);
      if (beat_log.size() == 8) check("t3_data7", beat_log[7].data, 64'hFFFFBFC7_00004038);

      // queue fill with ready low: 1 active + 4 queued
      clear_logs();
      ready_mode = 0;
      repeat (2) @(posedge clock);
      #1 accepted = 0;
      for (int i = 0; i < 6; i++) begin
         send_cmd(32'h5000 + 32'(i * 256), 8'd3, 21'(16 + i), 12, ok);
         if (ok) accepted++;
      end
      check("t4_accepted", 64'(accepted), 64'd5);
      @(negedge clock);
      check("t4_cmd_ready_low", 64'(io_vmeCmd_ready), 64'd0);
      @(posedge clock);
      #1 ready_mode = 1;
      wait_idle("t4_drain", 300);
      check("t4_beats", 64'(beat_log.size()), 64'd20);

      // back-to-back commands, then address wrap
      clear_logs();
      send_cmd(32'h2000, 8'd1, 21'd1, 10, ok);
      send_cmd(32'h3000, 8'd1, 21'd2, 10, ok);
      wait_idle("t5_drain", 60);
      check("t5_beats", 64'(beat_log.size()), 64'd4);
      if (beat_log.size() == 4) begin
         check("t5_beat_span", 64'(beat_cyc_log[3] - beat_cyc_log[0]), 64'd3);
         check("t5_lasts", {beat_log[0].last, beat_log[1].last, beat_log[2].last, beat_log[3].last}, 64'b0101);
         check("t5_tags", {beat_log[1].tag, beat_log[2].tag}, {21'd1, 21'd2});
      end
      clear_logs();
      send_cmd(32'hFFFFFFF8, 8'd1, 21'd3, 10, ok);
      wait_idle("t5w_drain", 40);
      if (mem_addr_log.size() == 2) check("t5w_addr1", 64'(mem_addr_log[1]), 64'h0);
      if (beat_log.size() == 2) check("t5w_data1", beat_log[1].data, 64'hFFFFFFFF_00000000);

      // reset mid-burst, then a fresh command
      send_cmd(32'h6000, 8'd7, 21'd9, 10, ok);
      repeat (4) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("t6_valid_in_reset", 64'(io_vmeData_valid), 64'd0);
      check("t6_busy_in_reset", 64'(io_busy), 64'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      clear_logs();
      send_cmd(32'h100, 8'd0, 21'h7, 10, ok);
      wait_idle("t6_drain", 40);
      check("t6_beats", 64'(beat_log.size()), 64'd1);
      if (beat_log.size() == 1) begin
         check("t6_data_lat", 64'(beat_cyc_log[0] - fire_cyc), 64'd4);
         check("t6_data", beat_log[0].data, 64'hFFFFFEFF_00000100);
         check("t6_tag", 64'(beat_log[0].tag), 64'h7);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
